// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants and helpers for the valid/ready pipeline register chain.
package pipe_reg_chain_pkg;

    localparam int DEFAULT_WIDTH  = 10;
    localparam int DEFAULT_STAGES = 3;

    // Bits needed to hold a count in the range 0..n inclusive.
    function automatic int clog2p1(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pipe_reg_chain_stage.sv
// One pipeline slot: a valid bit plus a data register that only captures real words.
module pipe_stage
    import pipe_reg_chain_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             load,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    output logic             v,
    output logic             v_next,
    output logic [WIDTH-1:0] d
);

    logic             v_reg;
    logic [WIDTH-1:0] d_reg;

    always_comb begin
        v_next = v_reg;
        if (reset || flush) begin
            v_next = 1'b0;
        end else if (load) begin
            v_next = up_valid;
        end
    end

    always_ff @(posedge clk) begin
        v_reg <= v_next;
        if (reset) begin
            if (CLEAR_DATA) begin
                d_reg <= '0;
            end
        end else if (load && up_valid && !flush) begin
            // Bubbles are never copied, so idle data registers do not toggle.
            d_reg <= up_data;
        end
    end

    assign v = v_reg;
    assign d = d_reg;

endmodule

// File: rtl/pipe_reg_chain.sv
// WIDTH-bit, STAGES-deep register chain with per-stage valid/ready, flush and occupancy.
module pipe_reg_chain
    import pipe_reg_chain_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int STAGES     = DEFAULT_STAGES,
    parameter bit CLEAR_DATA = 1'b1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [WIDTH-1:0]               out_data,
    output logic [clog2p1(STAGES)-1:0]     occupancy
);

    localparam int OCC_W = clog2p1(STAGES);

    logic [STAGES-1:0] v;
    logic [STAGES-1:0] v_next;
    logic [STAGES-1:0] up_valid;
    logic [STAGES:0]   rdy;
    logic [WIDTH-1:0]  d       [STAGES];
    logic [WIDTH-1:0]  up_data [STAGES];
    logic [OCC_W-1:0]  occ_next;
    logic [OCC_W-1:0]  occupancy_reg;

    // A stage can take a word if it is empty or its own word moves on this cycle.
    always_comb begin
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            rdy[k] = !v[k] || rdy[k+1];
        end
    end

    assign in_ready = rdy[0] && !flush;

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        if (gi == 0) begin : g_head
            assign up_valid[gi] = in_valid && in_ready;
            assign up_data[gi]  = in_data;
        end else begin : g_body
            assign up_valid[gi] = v[gi-1];
            assign up_data[gi]  = d[gi-1];
        end

        pipe_stage #(
            .WIDTH      (WIDTH),
            .CLEAR_DATA (CLEAR_DATA)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .load     (rdy[gi]),
            .up_valid (up_valid[gi]),
            .up_data  (up_data[gi]),
            .v        (v[gi]),
            .v_next   (v_next[gi]),
            .d        (d[gi])
        );
    end

    always_comb begin
        occ_next = '0;
        for (int k = 0; k < STAGES; k++) begin
            occ_next = occ_next + OCC_W'(v_next[k]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            occupancy_reg <= '0;
        end else begin
            occupancy_reg <= occ_next;
        end
    end

    assign occupancy = occupancy_reg;
    assign out_valid = v[STAGES-1];
    assign out_data  = d[STAGES-1];

    // A stalled output word must stay put until the consumer takes it.
    out_hold_a: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain with an output scoreboard and a CLEAR_DATA=0 twin.
module tb_pipe_reg_chain;

    localparam int WIDTH  = 10;
    localparam int STAGES = 3;
    localparam int OW     = $clog2(STAGES + 1);

    logic             clk = 1'b0;
    logic             reset, flush, in_valid, out_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_ready, out_valid;
    logic [WIDTH-1:0] out_data;
    logic [OW-1:0]    occupancy;
    logic             nc_in_ready, nc_out_valid;
    logic [WIDTH-1:0] nc_out_data;
    logic [OW-1:0]    nc_occupancy;

    int total = 0;
    int bad   = 0;
    logic [WIDTH-1:0] sb [$];

    always #5 clk = ~clk;

    pipe_reg_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .CLEAR_DATA(1'b1)) u_dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    pipe_reg_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .CLEAR_DATA(1'b0)) u_dut_nc (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(nc_in_ready), .in_data(in_data),
        .out_valid(nc_out_valid), .out_ready(out_ready), .out_data(nc_out_data),
        .occupancy(nc_occupancy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: outputs are compared before this cycle's input is queued.
    logic             prev_stalled = 1'b0;
    logic [WIDTH-1:0] prev_data    = '0;
    always @(negedge clk) begin
        logic [WIDTH-1:0] exp_word;
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", {22'd0, out_data}, 32'hFFFF_FFFF);
            end else begin
                exp_word = sb.pop_front();
                $display("out word %03h expected %03h", out_data, exp_word);
                check("out_word", {22'd0, out_data}, {22'd0, exp_word});
            end
        end
        if (reset || flush) begin
            sb.delete();
        end else if (in_valid && in_ready) begin
            sb.push_back(in_data);
            $display("in  word %03h", in_data);
        end
        if (prev_stalled) begin
            assert (in_valid && in_data == prev_data)
                else $error("producer dropped a pending word");
        end
        prev_stalled = in_valid && !in_ready && !flush && !reset;
        prev_data    = in_data;
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        step(); step();
        reset = 1'b0;
        #1;
        check("init_in_ready", 32'(in_ready), 32'd1);
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_occupancy", 32'(occupancy), 32'd0);

        // Reset of a pre-filled chain.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 10'h111; step();
        in_data = 10'h222; step();
        in_data = 10'h333; step();
        in_valid = 1'b0;
        check("prefill_occupancy", 32'(occupancy), 32'd3);
        reset = 1'b1; step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h000);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        reset = 1'b0; #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // Streaming at one word per cycle.
        out_ready = 1'b1; in_valid = 1'b1;
        in_data = 10'h001; step(); check("stream_in_ready1", 32'(in_ready), 32'd1);
        in_data = 10'h002; step(); check("stream_in_ready2", 32'(in_ready), 32'd1);
        in_data = 10'h003; step(); check("stream_in_ready3", 32'(in_ready), 32'd1);
        check("stream_latency_valid", 32'(out_valid), 32'd1);
        check("stream_latency_data", 32'(out_data), 32'h001);
        in_data = 10'h3FF; step(); check("stream_in_ready4", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        step(); step(); step();
        check("stream_drained", 32'(occupancy), 32'd0);

        // Back-pressure fills from the output end.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 10'h0A1; step();
        in_data = 10'h0A2; step();
        in_data = 10'h0A3; step();
        in_data = 10'h0A4; #1;
        check("bp_in_ready_full", 32'(in_ready), 32'd0);
        check("bp_occupancy", 32'(occupancy), 32'd3);
        step(); step();
        check("bp_hold_occupancy", 32'(occupancy), 32'd3);
        out_ready = 1'b1; #1;
        check("bp_out0", 32'(out_data), 32'h0A1);
        step(); in_valid = 1'b0;
        check("bp_out1_valid", 32'(out_valid), 32'd1);
        check("bp_out1", 32'(out_data), 32'h0A2);
        step();
        check("bp_out2_valid", 32'(out_valid), 32'd1);
        check("bp_out2", 32'(out_data), 32'h0A3);
        step();
        check("bp_out3_valid", 32'(out_valid), 32'd1);
        check("bp_out3", 32'(out_data), 32'h0A4);
        step();
        check("bp_empty", 32'(out_valid), 32'd0);

        // Bubble collapse behind a stalled output.
        out_ready = 1'b0; in_valid = 1'b1; in_data = 10'h0C1; step();
        in_valid = 1'b0; step(); step();
        in_valid = 1'b1; in_data = 10'h0C2; step();
        in_valid = 1'b0; step();
        check("bubble_occupancy", 32'(occupancy), 32'd2);
        check("bubble_in_ready", 32'(in_ready), 32'd1);
        check("bubble_out_data", 32'(out_data), 32'h0C1);
        out_ready = 1'b1; step(); step(); step();
        check("bubble_drained", 32'(occupancy), 32'd0);

        // Flush of a full chain, with a competing input word.
        out_ready = 1'b0; in_valid = 1'b1;
        in_data = 10'h0B1; step();
        in_data = 10'h0B2; step();
        in_data = 10'h0B3; step();
        in_data = 10'h0B4; flush = 1'b1; #1;
        check("flush_in_ready", 32'(in_ready), 32'd0);
        check("flush_shows_data", 32'(out_data), 32'h0B1);
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("flush_occupancy", 32'(occupancy), 32'd0);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("flush_no_old_word", 32'(out_valid), 32'd0);
        end

        // Reset mid-stream; the CLEAR_DATA=0 twin keeps its data registers.
        in_valid = 1'b1;
        in_data = 10'h0D1; step();
        in_data = 10'h0D2; step();
        in_valid = 1'b0; reset = 1'b1; step();
        reset = 1'b0;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_occupancy", 32'(occupancy), 32'd0);
        check("mid_rst_nc_out_valid", 32'(nc_out_valid), 32'd0);
        check("mid_rst_nc_occupancy", 32'(nc_occupancy), 32'd0);
        check("mid_rst_cleared_data", 32'(out_data), 32'h000);
        check("mid_rst_nc_held_data", 32'(nc_out_data), 32'h0B1);
        in_valid = 1'b1; in_data = 10'h155; step();
        in_valid = 1'b0;
        check("mid_rst_no_partial1", 32'(nc_out_valid), 32'd0);
        step();
        check("mid_rst_no_partial2", 32'(nc_out_valid), 32'd0);
        step();
        check("mid_rst_nc_valid", 32'(nc_out_valid), 32'd1);
        check("mid_rst_nc_data", 32'(nc_out_data), 32'h155);
        check("mid_rst_data", 32'(out_data), 32'h155);
        step();
        check("mid_rst_alone", 32'(nc_out_valid), 32'd0);
        check("mid_rst_final_occ", 32'(nc_occupancy), 32'd0);

        step();
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
